// File: rtl/vga_line_fetch.sv
// VGA line prefetch: copies one 256-byte framebuffer row (64 words) from memory into the line buffer.
// Optional VGA_LINE_REPEAT_EN skips the fetch when the requested row is already in the buffer.
module vga_line_fetch #(
  parameter logic [15:0] FB_BASE = 16'h4000,
  parameter int unsigned LINES   = 192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [7:0]  line_num,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state, state_n;
  logic [15:0] row_base, row_base_n, mem_addr_n, new_base;
  logic [5:0]  widx, widx_n, wr_addr_n;
  logic [31:0] wr_data_n;
  logic        wr_en_n, done_n, overrun_n;
  logic        line_ok, repeat_hit;

  assign line_ok  = {24'd0, line_num} < LINES;
  assign new_base = FB_BASE + {line_num, 8'h00};
  assign mem_req  = (state == FETCH);
  assign busy     = (state == FETCH);

`ifdef VGA_LINE_REPEAT_EN
  logic [7:0] row, last_row;
  logic       last_valid;

  assign repeat_hit = last_valid && (last_row == line_num);

  // row tracks the most recent line_start; any later line_start aborts, so at
  // completion it always names the row just written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      last_row   <= '0;
      last_valid <= 1'b0;
    end else begin
      if (line_start)
        row <= line_num;
      if (state == FETCH && line_start)
        last_valid <= 1'b0;
      else if (state == FETCH && mem_ack && widx == 6'd63) begin
        last_valid <= 1'b1;
        last_row   <= row;
      end
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    row_base_n = row_base;
    widx_n     = widx;
    mem_addr_n = mem_addr;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    done_n     = 1'b0;
    overrun_n  = 1'b0;

    // An accepted word is always written, even in an abort cycle
    if (mem_req && mem_ack) begin
      wr_en_n   = 1'b1;
      wr_addr_n = widx;
      wr_data_n = mem_data;
    end

    unique case (state)
      IDLE: begin
        if (line_start && line_ok) begin
          if (repeat_hit) begin
            done_n = 1'b1;
          end else begin
            state_n    = FETCH;
            row_base_n = new_base;
            widx_n     = '0;
            mem_addr_n = new_base;
          end
        end
      end
      FETCH: begin
        if (line_start) begin
          overrun_n = 1'b1;
          if (line_ok) begin
            row_base_n = new_base;
            widx_n     = '0;
            mem_addr_n = new_base;
          end else begin
            state_n = IDLE;
          end
        end else if (mem_ack) begin
          if (widx == 6'd63) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            widx_n     = widx + 6'd1;
            mem_addr_n = row_base + {8'h00, widx + 6'd1, 2'b00};
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row_base <= '0;
      widx     <= '0;
      mem_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      row_base <= row_base_n;
      widx     <= widx_n;
      mem_addr <= mem_addr_n;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      done     <= done_n;
      overrun  <= overrun_n;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch; a second instance uses FB_BASE = 16'hFF00 for the wrap case.
module tb_vga_line_fetch;

  logic        clk, rst_n, line_start, mem_ack;
  logic [7:0]  line_num;
  logic        mem_req, wr_en, busy, done, overrun;
  logic [15:0] mem_addr;
  logic [5:0]  wr_addr;
  logic [31:0] mem_data, wr_data;
  logic        mem_req2, wr_en2, busy2, done2, overrun2;
  logic [15:0] mem_addr2;
  logic [5:0]  wr_addr2;
  logic [31:0] mem_data2, wr_data2;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] fdat(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // memory model: each word's content is a fixed function of its address
  assign mem_data  = fdat(mem_addr);
  assign mem_data2 = fdat(mem_addr2);

  vga_line_fetch dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_num(line_num),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  vga_line_fetch #(.FB_BASE(16'hFF00), .LINES(192)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_num(line_num),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack), .mem_data(mem_data2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .done(done2), .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({mem_req, mem_addr, wr_en, wr_addr, wr_data, busy, done, overrun} !== 60'd0)
      $display("FAIL reset_outputs got=%h want=0",
               {mem_req, mem_addr, wr_en, wr_addr, wr_data, busy, done, overrun});
    total++;
    if ({mem_req2, mem_addr2, wr_en2, busy2, done2, overrun2} !== 21'd0)
      $display("FAIL reset_outputs_wrap got=%h want=0",
               {mem_req2, mem_addr2, wr_en2, busy2, done2, overrun2});
    if ({mem_req, mem_addr, wr_en, wr_addr, wr_data, busy, done, overrun} !== 60'd0) bad++;
    if ({mem_req2, mem_addr2, wr_en2, busy2, done2, overrun2} !== 21'd0) bad++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_row0();
    logic [4:0] exp_ctl;
    line_num = 8'd0; line_start = 1'b1; mem_ack = 1'b1;
    step();
    line_start = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      exp_ctl = {c <= 64, c <= 64, c >= 2 && c <= 65, c == 65, 1'b0};
      total++;
      if ({mem_req, busy, wr_en, done, overrun} !== exp_ctl) begin
        bad++;
        $display("FAIL row0_ctl c=%0d got=%b want=%b", c, {mem_req, busy, wr_en, done, overrun}, exp_ctl);
      end
      if (c <= 64) begin
        total++;
        if (mem_addr !== 16'h4000 + 16'((c - 1) * 4)) begin
          bad++;
          $display("FAIL row0_addr c=%0d got=%h want=%h", c, mem_addr, 16'h4000 + 16'((c - 1) * 4));
        end
      end
      if (c >= 2 && c <= 65) begin
        total++;
        if ({wr_addr, wr_data} !== {6'(c - 2), fdat(16'h4000 + 16'((c - 2) * 4))}) begin
          bad++;
          $display("FAIL row0_write c=%0d got=%h/%h want=%h/%h", c, wr_addr, wr_data,
                   6'(c - 2), fdat(16'h4000 + 16'((c - 2) * 4)));
        end
      end
      if (c < 66) step();
    end
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_slow_ack();
    int w, writes, dones;
    logic ex_wr, ex_done;
    logic [5:0] ex_addr;
    logic [31:0] ex_data;
    w = 0; writes = 0; dones = 0; ex_wr = 1'b0; ex_done = 1'b0; ex_addr = '0; ex_data = '0;
    line_num = 8'd191; line_start = 1'b1; mem_ack = 1'b0;
    step();
    line_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      total++;
      if ({mem_req, wr_en, done} !== {w < 64, ex_wr, ex_done}) begin
        bad++;
        $display("FAIL slow_ctl c=%0d got=%b want=%b", c, {mem_req, wr_en, done}, {w < 64, ex_wr, ex_done});
      end
      if (w < 64) begin
        total++;
        if (mem_addr !== 16'hFF00 + 16'(w * 4)) begin
          bad++;
          $display("FAIL slow_addr c=%0d got=%h want=%h", c, mem_addr, 16'hFF00 + 16'(w * 4));
        end
      end
      if (ex_wr) begin
        total++;
        if ({wr_addr, wr_data} !== {ex_addr, ex_data}) begin
          bad++;
          $display("FAIL slow_write c=%0d got=%h/%h want=%h/%h", c, wr_addr, wr_data, ex_addr, ex_data);
        end
      end
      if (wr_en === 1'b1) writes++;
      if (done === 1'b1) dones++;
      mem_ack = (c % 3 == 0);
      ex_wr   = mem_ack && w < 64;
      ex_done = mem_ack && w == 63;
      ex_addr = 6'(w);
      ex_data = fdat(16'hFF00 + 16'(w * 4));
      if (ex_wr) w++;
      step();
    end
    mem_ack = 1'b0;
    total++;
    if (writes != 64 || dones != 1) begin
      bad++;
      $display("FAIL slow_counts got=%0d/%0d want=64/1", writes, dones);
    end
    step();
  endtask

  task automatic test_wrap();
    line_num = 8'd1; line_start = 1'b1; mem_ack = 1'b1;
    step();
    line_start = 1'b0;
    for (int c = 1; c <= 65; c++) begin
      total++;
      if ({mem_req2, done2} !== {c <= 64, c == 65}) begin
        bad++;
        $display("FAIL wrap_ctl c=%0d got=%b want=%b", c, {mem_req2, done2}, {c <= 64, c == 65});
      end
      if (c <= 64) begin
        total++;
        if (mem_addr2 !== 16'((c - 1) * 4)) begin
          bad++;
          $display("FAIL wrap_addr c=%0d got=%h want=%h", c, mem_addr2, 16'((c - 1) * 4));
        end
      end
      if (c == 2) begin
        total++;
        if ({wr_en2, wr_addr2, wr_data2} !== {1'b1, 6'd0, fdat(16'h0000)}) begin
          bad++;
          $display("FAIL wrap_write got=%b/%h/%h want=1/0/%h", wr_en2, wr_addr2, wr_data2, fdat(16'h0000));
        end
      end
      step();
    end
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    int dones;
    dones = 0;
    line_num = 8'd4; line_start = 1'b1; mem_ack = 1'b1;
    step();
    line_start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      total++;
      if ({overrun, done, mem_req} !== {c == 11, c == 75, c < 75}) begin
        bad++;
        $display("FAIL ovr_ctl c=%0d got=%b want=%b", c, {overrun, done, mem_req}, {c == 11, c == 75, c < 75});
      end
      if (done === 1'b1) dones++;
      if (c <= 10) begin
        total++;
        if (mem_addr !== 16'h4400 + 16'((c - 1) * 4)) begin
          bad++;
          $display("FAIL ovr_addr_old c=%0d got=%h want=%h", c, mem_addr, 16'h4400 + 16'((c - 1) * 4));
        end
      end else if (c <= 74) begin
        total++;
        if (mem_addr !== 16'h4500 + 16'((c - 11) * 4)) begin
          bad++;
          $display("FAIL ovr_addr_new c=%0d got=%h want=%h", c, mem_addr, 16'h4500 + 16'((c - 11) * 4));
        end
      end
      if (c == 11) begin
        total++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd9, fdat(16'h4424)}) begin
          bad++;
          $display("FAIL ovr_last_write got=%b/%h/%h want=1/09/%h", wr_en, wr_addr, wr_data, fdat(16'h4424));
        end
      end
      if (c == 12) begin
        total++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd0, fdat(16'h4500)}) begin
          bad++;
          $display("FAIL ovr_first_write got=%b/%h/%h want=1/00/%h", wr_en, wr_addr, wr_data, fdat(16'h4500));
        end
      end
      if (c == 10) begin
        line_num = 8'd5; line_start = 1'b1;
      end else begin
        line_start = 1'b0;
      end
      step();
    end
    mem_ack = 1'b0;
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL ovr_done_count got=%0d want=1", dones);
    end
  endtask

  task automatic test_invalid();
    line_num = 8'd200; line_start = 1'b1; mem_ack = 1'b1;
    step();
    line_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if ({mem_req, busy, done, overrun, wr_en} !== 5'b0) begin
        bad++;
        $display("FAIL invalid_row c=%0d got=%b want=00000", c, {mem_req, busy, done, overrun, wr_en});
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    line_num = 8'd3; line_start = 1'b1; mem_ack = 1'b1;
    step();
    line_start = 1'b0;
    for (int c = 1; c < 31; c++) step();
    total++;
    if (mem_addr !== 16'h4378) begin
      bad++;
      $display("FAIL rst_mid_addr got=%h want=4378", mem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_addr, wr_en, wr_addr, wr_data, busy, done, overrun} !== 60'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%h want=0",
               {mem_req, mem_addr, wr_en, wr_addr, wr_data, busy, done, overrun});
    end
    mem_ack = 1'b0;
    #1 rst_n = 1'b1;
    step();
    total++;
    if ({mem_req, wr_en, done} !== 3'b0) begin
      bad++;
      $display("FAIL rst_mid_after got=%b want=000", {mem_req, wr_en, done});
    end
  endtask

  task automatic test_back_to_back();
    int reqs, writes, dcyc, dones, exp_reqs, exp_dcyc;
    reqs = 0; writes = 0; dcyc = 0; dones = 0;
`ifdef VGA_LINE_REPEAT_EN
    exp_reqs = 0; exp_dcyc = 1;
`else
    exp_reqs = 64; exp_dcyc = 65;
`endif
    line_num = 8'd7; line_start = 1'b1; mem_ack = 1'b1;
    step();
    line_start = 1'b0;
    for (int c = 1; c < 65; c++) step();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_done got=%b want=1", done);
    end
    line_start = 1'b1;  // issued while done is high
    step();
    line_start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (mem_req === 1'b1) reqs++;
      if (wr_en === 1'b1) writes++;
      if (done === 1'b1) begin
        dones++;
        if (dcyc == 0) dcyc = c;
      end
      step();
    end
    mem_ack = 1'b0;
    total++;
    if (reqs != exp_reqs || writes != exp_reqs || dcyc != exp_dcyc || dones != 1) begin
      bad++;
      $display("FAIL b2b_second got=req%0d wr%0d done@%0d n%0d want=req%0d wr%0d done@%0d n1",
               reqs, writes, dcyc, dones, exp_reqs, exp_reqs, exp_dcyc);
    end
  endtask

  initial begin
    rst_n = 1'b0; line_start = 1'b0; line_num = 8'd0; mem_ack = 1'b0;
    test_reset();
    test_row0();
    test_slow_ack();
    test_wrap();
    test_overrun();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Line prefetch engine for the VGA path. On each line-start pulse from the VGA timing generator it reads one 256-byte framebuffer row from main memory as 64 32-bit words over a req/ack port, then writes them into the VGA line buffer through that buffer's 32-bit write port (`wr_en` / `wr_addr[5:0]` / `wr_data[31:0]`). The pixel side then reads the same row back as 8-bit bytes.

## Interface
- `FB_BASE`, 16'h4000: byte address of framebuffer row 0.
- `LINES`, 192: number of valid rows; `line_num` >= `LINES` is ignored.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `line_start` in 1: one-cycle pulse requesting a fetch of row `line_num`.
- `line_num` in 8: row index, sampled only on `line_start`.
- `mem_req` out 1: read request, held until acknowledged.
- `mem_addr` out 16: byte address of the requested word, 4-byte aligned.
- `mem_ack` in 1: request accepted; `mem_data` is valid in the same cycle.
- `mem_data` in 32: read data.
- `wr_en` out 1: line buffer write strobe.
- `wr_addr` out 6: line buffer word index.
- `wr_data` out 32: line buffer write data.
- `busy` out 1: high while in FETCH.
- `done` out 1: one-cycle pulse when a row is complete in the buffer.
- `overrun` out 1: one-cycle pulse when a fetch is aborted by a new `line_start`.

## Operation
- FSM states: IDLE and FETCH.
- IDLE → FETCH: on `line_start` with `line_num` < `LINES`.
  - Latch `row_base = FB_BASE + {line_num, 8'h00}`. The sum is 16-bit and wraps modulo 2^16.
  - Clear the word counter `widx` (6 bits).
- In IDLE, `line_start` with `line_num` >= `LINES` is ignored: no request, no `done`, no `overrun`.
- FETCH:
  - `mem_req` = 1 and `mem_addr = row_base + {widx, 2'b00}`. Both are held stable until `mem_ack`.
  - On a cycle with `mem_req` && `mem_ack`, register `wr_en` = 1, `wr_addr` = `widx`, `wr_data` = `mem_data` for the next cycle, then increment `widx`.
  - Back-to-back acks are allowed: one word per cycle.
- Completion: the ack for `widx` = 63 moves the FSM to IDLE and drops `mem_req` in the next cycle. `done` pulses in the same cycle as the final `wr_en`.
- `mem_ack` while `mem_req` = 0 is ignored.
- `line_start` during FETCH:
  - Abort the current row and pulse `overrun`.
  - Restart at word 0 of the new `line_num` if it is valid; otherwise go to IDLE.
  - No `done` is issued for the aborted row.
  - An ack in that same cycle is still written (registered write completes); the counter then restarts.
- Reset mid-fetch: all state clears asynchronously and `mem_req` drops immediately. A partial row may remain in the buffer.
- Reset values: `mem_req` 0, `mem_addr` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `done` 0, `overrun` 0, FSM IDLE.

## Timing
- `line_start` sampled high at edge 0 → `mem_req` and `busy` high from cycle 1.
- Write latency: one cycle from `mem_ack` to `wr_en`.
- Minimum row time with `mem_ack` tied high:
  - requests in cycles 1–64;
  - writes in cycles 2–65;
  - `done` in cycle 65;
  - `busy` low from cycle 65.
- A new `line_start` is accepted in the same cycle that `done` is high.
- All outputs are registered. No combinational path from `mem_ack`/`mem_data` to `wr_*`.

## Configuration
- `VGA_LINE_REPEAT_EN` defined:
  - Keep the row number of the last fetch that completed with `done`, plus a valid flag.
  - A `line_start` in IDLE whose `line_num` matches the kept row issues no memory traffic, no writes, and pulses `done` one cycle later (cycle 1).
  - Reset clears the valid flag. An aborted fetch clears the valid flag.
  - Purpose: supports scan-doubled modes where each row is shown twice.
- Undefined: every valid `line_start` performs a full 64-word fetch.

## Test plan
- Row 0, ack tied high: `line_start` at cycle 0 → `mem_addr` 0x4000…0x40FC in cycles 1–64, `wr_addr` 0–63 in cycles 2–65, `done` at 65.
- Row 191, ack high every third cycle: `mem_addr` starts at 0xFF00 and stays stable while unacked; exactly 64 writes with correct data; one `done`.
- `FB_BASE` = 16'hFF00, row 1: the address wraps to 0x0000–0x00FC.
- `line_start` row 5 at cycle 10 of a row-4 fetch → `overrun` pulse, `mem_addr` jumps to 0x4500, one `done` only.
- `line_num` = 200 → no `mem_req`, no `done`. `rst_n` low at word 30 → all outputs 0 in the same cycle.
- With `VGA_LINE_REPEAT_EN`: row 7 twice → second `line_start` gives zero `mem_req` and `done` at cycle 1. Without the macro → two full fetches.
